// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
// Holds widths, the NOP encoding, the fetch FSM states and the IF/ID bundle.
package mips_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc4;
        logic              valid;
    } ifid_t;

    localparam ifid_t IFID_FLUSH = '{instr: NOP, pc4: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and a combinational memory.
// master: drives imem_addr, reads imem_data. slave: the reverse.
interface fetch_unit_if
    import mips_pkg::*;
();

    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;

    modport master (
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        output imem_data
    );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: branch over jump over sequential pc+4.
// Ports: pc, br_taken/br_target, jmp_taken/jmp_index in;
//        redirect, next_pc, misalign (raw branch target low bits set) out.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_taken,
    input  logic [25:0]       jmp_index,
    output logic              redirect,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    always_comb begin
        redirect = br_taken | jmp_taken;
        misalign = 1'b0;
        next_pc  = pc + ADDR_W'(4);
        // Both redirects may be asserted together; the branch belongs to
        // the older instruction, so priority (not unique) is intended.
        priority case (1'b1)
            br_taken: begin
                next_pc  = {br_target[ADDR_W-1:2], 2'b00};
                misalign = |br_target[1:0];
            end
            jmp_taken: begin
                next_pc = {jmp_index, 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID register; handles stall, flush on redirect and halt.
// Ports: clk, rst_n (sync, active-low), stall, br_*, jmp_*, imem bus,
//        ifid_instr/ifid_pc4/ifid_valid, halted, misalign_err.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       MEM_BYTES = 372,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_taken,
    input  logic [25:0]       jmp_index,
    fetch_unit_if.master      imem,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic              ifid_valid,
    output logic              halted,
    output logic              misalign_err
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic              mis_q, mis_d;

    logic              redirect;
    logic [ADDR_W-1:0] next_pc;
    logic              misalign;

    pc_next_sel u_sel (
        .pc        (pc_q),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp_taken (jmp_taken),
        .jmp_index (jmp_index),
        .redirect  (redirect),
        .next_pc   (next_pc),
        .misalign  (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ifid_q  <= IFID_FLUSH;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        mis_d   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d   = next_pc;
                    ifid_d = IFID_FLUSH;
                    mis_d  = misalign;
                end else if (!stall) begin
                    // The range check also catches pc+4 wrapping.
                    if (pc_q > LAST_PC) begin
                        state_d = HALT;
                        ifid_d  = IFID_FLUSH;
                    end else begin
                        pc_d   = next_pc;
                        ifid_d = '{instr: imem.imem_data,
                                   pc4:   next_pc,
                                   valid: 1'b1};
                    end
                end
            end
            HALT: begin
                ifid_d = IFID_FLUSH;
            end
        endcase
    end

    assign imem.imem_addr = pc_q;
    assign ifid_instr     = ifid_q.instr;
    assign ifid_pc4       = ifid_q.pc4;
    assign ifid_valid     = ifid_q.valid;
    assign halted         = (state_q == HALT);
    assign misalign_err   = mis_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 32-bit MIPS pipeline, directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Selects the next PC from three sources: sequential, branch redirect from EX, or jump redirect from ID.
- Captures the returned word into the IF/ID pipeline register, with stall, flush and end-of-program halt handling.

Parameters:
- ADDR_W, 28: PC / instruction-memory byte-address width.
- DATA_W, 32: instruction width.
- MEM_BYTES, 372: instruction memory size in bytes; the last legal fetch address is MEM_BYTES-4.
- RESET_PC, 0: PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hazard hold from ID; PC and IF/ID keep their values.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  ADDR_W  absolute branch target byte address.
- jmp_taken  in  1  ID-stage J-type jump.
- jmp_index  in  26  instr_index field of the jump.
- imem_addr  out  ADDR_W  byte address to instruction memory; equals pc.
- imem_data  in  DATA_W  instruction word returned combinationally for imem_addr.
- ifid_instr  out  DATA_W  IF/ID instruction register.
- ifid_pc4  out  ADDR_W  IF/ID copy of pc+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch has run past the end of memory.
- misalign_err  out  1  one-cycle pulse: a redirect target had nonzero low bits.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - rst_n=0 at an edge: pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0, misalign_err=0, state=FETCH.
  - rst_n overrides every other input, including mid-stall, mid-redirect and in HALT.
- imem_addr = pc, purely combinational. The fetch latency is one cycle: the word at pc appears on ifid_instr after the next edge.
- Jump target: {jmp_index, 2'b00}, exactly ADDR_W bits.
- Redirect target alignment:
  - target[1:0] is forced to 00.
  - misalign_err pulses high for one cycle when the raw branch target's low bits are nonzero.
  - The jump target is always aligned.
- pc+4 arithmetic is modulo 2^ADDR_W, with no carry out. The halt check below catches the wrap case first.
- FSM states: FETCH, HALT.
- FETCH, priority per edge (highest first):
  1. br_taken: pc<=aligned br_target; IF/ID flushed (instr=0 NOP, pc4=0, valid=0).
  2. jmp_taken: pc<=jump target; IF/ID flushed.
  3. stall: pc, ifid_* hold.
  4. pc > MEM_BYTES-4: state<=HALT, halted<=1, IF/ID flushed, pc holds.
  5. Otherwise: pc<=pc+4; ifid_instr<=imem_data; ifid_pc4<=pc+4; ifid_valid<=1.
- Priority consequences:
  - br_taken together with jmp_taken: the branch wins, because it comes from the older instruction.
  - A redirect overrides stall.
- Redirect to an out-of-range target is accepted. The halt check then fires on the following edge.
- HALT state:
  - Sticky until reset.
  - pc, imem_addr hold; ifid_valid=0; ifid_instr=0; halted=1.
  - stall and redirects are ignored.
- misalign_err is registered and is 0 in every cycle except the one after the offending redirect.

Decomposition:
- Shared package mips_pkg, holding:
  - ADDR_W and DATA_W constants;
  - the NOP encoding (32'h0000_0000);
  - fetch_state_t enum {FETCH, HALT};
  - the ifid_t packed struct {instr, pc4, valid}, reused by the decode stage.
- One natural sub-module: pc_next_sel, the combinational next-PC priority mux and alignment logic, instantiated once.
- The IF/ID register and the FSM stay in fetch_unit.

Test Plan:
- Reset then 4 free-running cycles:
  - imem_addr sequence 0,4,8,12.
  - ifid_instr after cycle 1 = 0x20080000, ifid_pc4=4, valid=1.
- stall high for 2 cycles at pc=8:
  - imem_addr stays 8; ifid_instr holds.
  - After release, the next capture is the word at 8 with pc4=12.
- br_taken=1, br_target=0x1E, plus jmp_taken=1, jmp_index=0x5, in the same cycle:
  - pc<=0x1C; misalign_err=1 for one cycle.
  - ifid_valid=0 and ifid_instr=0 on the next cycle.
- jmp_taken=1, jmp_index=0x3, with stall=1:
  - pc<=12, overriding the stall; IF/ID flushed.
- Free-run from 360:
  - Fetches 360, 364, 368.
  - At pc=372: HALT, halted=1, valid=0, imem_addr stays 372.
  - A later br_taken is ignored.
- rst_n=0 for one edge while in HALT, and while br_taken=1:
  - pc=0, halted=0, valid=0.
  - Normal fetch resumes at 0.
